// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit.
// Drives the data-memory request/response bus for the access held in EX/MEM,
// returns the aligned and extended load result on Mem_out (feeds MEM_WB), and
// raises stall to freeze IF..EX/MEM until the access completes.
//
// Optional feature macro: MISALIGN_TRAP_EN
//   defined   : misaligned half/word accesses skip the bus, pulse misalign_fault
//   undefined : misalign_fault tied low, misaligned accesses run as aligned
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   flush                       kill the MEM-stage access
//   MemRead, MemWrite           EX/MEM load / store request (both = store)
//   funct3                      RV32I access size/sign
//   addr, store_data            byte address, unshifted rs2 value
//   stall                       hold pipeline registers (combinational)
//   Mem_out                     extended load data (registered)
//   req_valid/ready/we/addr/wstrb/wdata   request channel
//   rsp_valid, rsp_rdata        read response channel
//   misalign_fault              one-cycle misaligned-access pulse
module mem_lsu #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] store_data,
    output logic              stall,
    output logic [DATA_W-1:0] Mem_out,
    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_we,
    output logic [ADDR_W-1:0] req_addr,
    output logic [3:0]        req_wstrb,
    output logic [DATA_W-1:0] req_wdata,
    input  logic              rsp_valid,
    input  logic [DATA_W-1:0] rsp_rdata,
    output logic              misalign_fault
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_RESP  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t state, state_nx;

    logic [1:0] lane_q;
    logic [2:0] f3_q;

    logic              access_c;
    logic              misalign_c;
    logic              capture_c;
    logic              load_upd_c;
    logic [3:0]        wstrb_c;
    logic [DATA_W-1:0] wdata_c;
    logic [7:0]        byte_c;
    logic [15:0]       half_c;
    logic [DATA_W-1:0] ld_c;

    assign access_c = MemRead | MemWrite;

    // Misalignment detection: size from funct3[1:0] (00 byte, 01 half, else word)
`ifdef MISALIGN_TRAP_EN
    always_comb begin
        misalign_c = 1'b0;
        case (funct3[1:0])
            2'b00:   misalign_c = 1'b0;
            2'b01:   misalign_c = addr[0];
            default: misalign_c = (addr[1:0] != 2'b00);
        endcase
    end
`else
    assign misalign_c = 1'b0;
`endif

    // Store lane formatting: replicate data across lanes, enable target bytes
    always_comb begin
        wstrb_c = 4'b1111;
        wdata_c = store_data;
        case (funct3[1:0])
            2'b00: begin
                wdata_c = {4{store_data[7:0]}};
                wstrb_c = 4'b0001 << addr[1:0];
            end
            2'b01: begin
                wdata_c = {2{store_data[15:0]}};
                wstrb_c = addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wdata_c = store_data;
                wstrb_c = 4'b1111;
            end
        endcase
    end

    // Load extraction from the captured lane and funct3
    always_comb begin
        case (lane_q)
            2'd0:    byte_c = rsp_rdata[7:0];
            2'd1:    byte_c = rsp_rdata[15:8];
            2'd2:    byte_c = rsp_rdata[23:16];
            default: byte_c = rsp_rdata[31:24];
        endcase
        half_c = lane_q[1] ? rsp_rdata[31:16] : rsp_rdata[15:0];
        case (f3_q)
            3'b000:  ld_c = {{24{byte_c[7]}}, byte_c};
            3'b100:  ld_c = {24'd0, byte_c};
            3'b001:  ld_c = {{16{half_c[15]}}, half_c};
            3'b101:  ld_c = {16'd0, half_c};
            default: ld_c = rsp_rdata;
        endcase
    end

    // Next-state and stall decode
    always_comb begin
        state_nx   = state;
        stall      = 1'b0;
        capture_c  = 1'b0;
        load_upd_c = 1'b0;
        case (state)
            S_IDLE: begin
                if (access_c && !flush) begin
                    stall     = 1'b1;
                    capture_c = 1'b1;
                    state_nx  = misalign_c ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                stall = 1'b1;
                if (req_ready) begin
                    // Accepted even when flushed; a flushed load still owes a response
                    if (req_we) state_nx = flush ? S_IDLE  : S_DONE;
                    else        state_nx = flush ? S_DRAIN : S_RESP;
                end else if (flush) begin
                    state_nx = S_IDLE;
                end
            end
            S_RESP: begin
                stall = 1'b1;
                if (rsp_valid) begin
                    // Response arriving with flush is consumed and discarded
                    if (flush) begin
                        state_nx = S_IDLE;
                    end else begin
                        load_upd_c = 1'b1;
                        state_nx   = S_DONE;
                    end
                end else if (flush) begin
                    state_nx = S_DRAIN;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            S_DRAIN: begin
                stall = 1'b1;
                if (rsp_valid) state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Request channel, captured access attributes and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_valid      <= 1'b0;
            req_we         <= 1'b0;
            req_addr       <= '0;
            req_wstrb      <= 4'd0;
            req_wdata      <= '0;
            lane_q         <= 2'd0;
            f3_q           <= 3'd0;
            Mem_out        <= '0;
            misalign_fault <= 1'b0;
        end else begin
            req_valid      <= (state_nx == S_REQ);
            misalign_fault <= capture_c & misalign_c;
            if (capture_c) begin
                req_we    <= MemWrite;
                req_addr  <= {addr[ADDR_W-1:2], 2'b00};
                req_wstrb <= MemWrite ? wstrb_c : 4'd0;
                req_wdata <= wdata_c;
                lane_q    <= addr[1:0];
                f3_q      <= funct3;
            end
            if (load_upd_c) Mem_out <= ld_c;
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed self-checking bench for mem_lsu. Inputs change and outputs are
// sampled just after the falling clock edge.
module tb_mem_lsu;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        stall;
    logic [31:0] Mem_out;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [3:0]  req_wstrb;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        misalign_fault;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_mem;

    mem_lsu dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .MemRead       (MemRead),
        .MemWrite      (MemWrite),
        .funct3        (funct3),
        .addr          (addr),
        .store_data    (store_data),
        .stall         (stall),
        .Mem_out       (Mem_out),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_wstrb     (req_wstrb),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .misalign_fault(misalign_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Load with ready on the first REQ cycle and response on the next cycle
    task automatic load_seq(input string tag, input logic [31:0] a, input logic [2:0] f3,
                            input logic [31:0] rd, input logic [31:0] exp);
        @(negedge clk);
        MemRead = 1'b1; MemWrite = 1'b0; addr = a; funct3 = f3;
        #1 chk({tag, "_stall_idle"}, 32'(stall), 32'd1);
        @(negedge clk);
        req_ready = 1'b1;
        #1;
        chk({tag, "_req_valid"}, 32'(req_valid), 32'd1);
        chk({tag, "_req_addr"}, req_addr, a & 32'hFFFF_FFFC);
        chk({tag, "_req_wstrb"}, 32'(req_wstrb), 32'd0);
        chk({tag, "_req_we"}, 32'(req_we), 32'd0);
        @(negedge clk);
        req_ready = 1'b0; rsp_valid = 1'b1; rsp_rdata = rd;
        #1;
        chk({tag, "_stall_resp"}, 32'(stall), 32'd1);
        chk({tag, "_valid_resp"}, 32'(req_valid), 32'd0);
        @(negedge clk);
        rsp_valid = 1'b0; MemRead = 1'b0;
        #1;
        chk({tag, "_stall_done"}, 32'(stall), 32'd0);
        chk({tag, "_mem_out"}, Mem_out, exp);
        exp_mem = exp;
    endtask

    // Store with req_ready held off for 'hold' REQ cycles
    task automatic store_seq(input string tag, input logic rd_too, input logic [31:0] a,
                             input logic [2:0] f3, input logic [31:0] sd,
                             input logic [31:0] exp_wdata, input logic [3:0] exp_wstrb,
                             input int hold);
        int stall_cnt;
        stall_cnt = 0;
        @(negedge clk);
        MemWrite = 1'b1; MemRead = rd_too; addr = a; funct3 = f3; store_data = sd;
        #1 if (stall) stall_cnt++;
        for (int i = 0; i <= hold; i++) begin
            @(negedge clk);
            req_ready = (i == hold);
            #1;
            if (stall) stall_cnt++;
            chk({tag, "_req_valid"}, 32'(req_valid), 32'd1);
            chk({tag, "_req_we"}, 32'(req_we), 32'd1);
            chk({tag, "_wdata"}, req_wdata, exp_wdata);
            chk({tag, "_wstrb"}, 32'(req_wstrb), 32'(exp_wstrb));
            chk({tag, "_addr"}, req_addr, a & 32'hFFFF_FFFC);
        end
        @(negedge clk);
        req_ready = 1'b0; MemWrite = 1'b0; MemRead = 1'b0;
        #1;
        chk({tag, "_stall_done"}, 32'(stall), 32'd0);
        chk({tag, "_valid_done"}, 32'(req_valid), 32'd0);
        chk({tag, "_mem_kept"}, Mem_out, exp_mem);
        chk({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(hold + 2));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        funct3 = 3'd0; addr = '0; store_data = '0;
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = '0;
        exp_mem = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_req_valid", 32'(req_valid), 32'd0);
        chk("rst_mem_out", Mem_out, 32'd0);
        chk("rst_fault", 32'(misalign_fault), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Loads across sizes, signs and lanes
        load_seq("lb",  32'h0000_1003, 3'b000, 32'h80FF_1234, 32'hFFFF_FF80);
        load_seq("lhu", 32'h0000_2002, 3'b101, 32'hBEEF_0000, 32'h0000_BEEF);
        load_seq("lh",  32'h0000_2002, 3'b001, 32'hBEEF_0000, 32'hFFFF_BEEF);
        load_seq("lbu", 32'h0000_1001, 3'b100, 32'h80FF_1234, 32'h0000_0012);
        load_seq("lh0", 32'h0000_2000, 3'b001, 32'h0000_7F01, 32'h0000_7F01);
        load_seq("lw",  32'h0000_5004, 3'b010, 32'h1234_5678, 32'h1234_5678);

        // Stores: delayed ready, half, word, and read+write treated as store
        store_seq("sb", 1'b0, 32'h0000_3001, 3'b000, 32'h0000_00AB, 32'hABAB_ABAB, 4'b0010, 2);
        store_seq("sh", 1'b0, 32'h0000_3002, 3'b001, 32'h1234_CAFE, 32'hCAFE_CAFE, 4'b1100, 0);
        store_seq("sw", 1'b0, 32'h0000_3008, 3'b010, 32'h1122_3344, 32'h1122_3344, 4'b1111, 0);
        store_seq("rw", 1'b1, 32'h0000_3000, 3'b000, 32'h0000_0055, 32'h5555_5555, 4'b0001, 1);

        // Flush in IDLE: request ignored
        @(negedge clk);
        MemRead = 1'b1; flush = 1'b1; addr = 32'h0000_7000; funct3 = 3'b010;
        #1 chk("fl_idle_stall", 32'(stall), 32'd0);
        @(negedge clk);
        MemRead = 1'b0; flush = 1'b0;
        #1 chk("fl_idle_valid", 32'(req_valid), 32'd0);

        // Flush in REQ before handshake: request withdrawn
        @(negedge clk);
        MemRead = 1'b1; addr = 32'h0000_7004; funct3 = 3'b010;
        @(negedge clk);
        flush = 1'b1;
        #1 chk("fl_req_valid", 32'(req_valid), 32'd1);
        @(negedge clk);
        flush = 1'b0; MemRead = 1'b0;
        #1;
        chk("fl_req_dropped", 32'(req_valid), 32'd0);
        chk("fl_req_stall", 32'(stall), 32'd0);

        // Flush in RESP: drain response, Mem_out untouched
        @(negedge clk);
        MemRead = 1'b1; addr = 32'h0000_6000; funct3 = 3'b010;
        @(negedge clk);
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0; flush = 1'b1;
        #1 chk("fl_resp_stall", 32'(stall), 32'd1);
        @(negedge clk);
        flush = 1'b0; MemRead = 1'b0;
        #1 chk("drain_stall0", 32'(stall), 32'd1);
        @(negedge clk);
        rsp_valid = 1'b1; rsp_rdata = 32'hDEAD_BEEF;
        #1 chk("drain_stall1", 32'(stall), 32'd1);
        @(negedge clk);
        rsp_valid = 1'b0;
        #1;
        chk("drain_stall_end", 32'(stall), 32'd0);
        chk("drain_mem_kept", Mem_out, exp_mem);

        // Flush coincident with load acceptance: goes to DRAIN
        @(negedge clk);
        MemRead = 1'b1; addr = 32'h0000_6010; funct3 = 3'b000;
        @(negedge clk);
        req_ready = 1'b1; flush = 1'b1;
        @(negedge clk);
        req_ready = 1'b0; flush = 1'b0; MemRead = 1'b0;
        #1 chk("flacc_stall", 32'(stall), 32'd1);
        @(negedge clk);
        rsp_valid = 1'b1; rsp_rdata = 32'h0102_0304;
        @(negedge clk);
        rsp_valid = 1'b0;
        #1;
        chk("flacc_stall_end", 32'(stall), 32'd0);
        chk("flacc_mem_kept", Mem_out, exp_mem);

        // Misaligned word load
`ifdef MISALIGN_TRAP_EN
        @(negedge clk);
        MemRead = 1'b1; addr = 32'h0000_4002; funct3 = 3'b010;
        #1 chk("mis_stall", 32'(stall), 32'd1);
        @(negedge clk);
        MemRead = 1'b0;
        #1;
        chk("mis_fault", 32'(misalign_fault), 32'd1);
        chk("mis_valid", 32'(req_valid), 32'd0);
        chk("mis_stall_done", 32'(stall), 32'd0);
        chk("mis_mem_kept", Mem_out, exp_mem);
        @(negedge clk);
        #1;
        chk("mis_fault_clr", 32'(misalign_fault), 32'd0);
        chk("mis_valid_idle", 32'(req_valid), 32'd0);
`else
        load_seq("lw_mis", 32'h0000_4002, 3'b010, 32'hCAFE_F00D, 32'hCAFE_F00D);
        chk("mis_fault_tied", 32'(misalign_fault), 32'd0);
`endif

        // Async reset during RESP
        @(negedge clk);
        MemRead = 1'b1; addr = 32'h0000_1000; funct3 = 3'b010;
        @(negedge clk);
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0; MemRead = 1'b0;
        #1 chk("rr_stall_pre", 32'(stall), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rr_stall", 32'(stall), 32'd0);
        chk("rr_req_valid", 32'(req_valid), 32'd0);
        chk("rr_mem_out", Mem_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_mem = 32'd0;
        load_seq("post_rst", 32'h0000_0002, 3'b100, 32'h00A5_0000, 32'h0000_00A5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
